// File: rtl/fifosc_uart_tx.sv
// Purpose: pops words from a fifosc read port and shifts each out as a UART frame (start, LSB-first data, stop).
// Latency: enable && !fifo_empty seen in IDLE at cycle t -> fifo_remove at t+1, start bit on txd at t+3.
// Backpressure: no pop unless enabled and non-empty in IDLE; a frame in progress always runs to completion.
module fifosc_uart_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  output logic                  fifo_remove,
  output logic                  txd,
  output logic                  busy,
  output logic [7:0]            frame_count
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [7:0]            frame_q, frame_d;
  logic                  txd_q, txd_d;
  logic                  remove_q, remove_d;
  logic                  busy_q, busy_d;

  logic tick_last;
  logic bit_last;

  assign tick_last = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BW'(DATA_WIDTH - 1));

  // State, datapath and registered outputs; reset aborts any frame and drops the popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      frame_q  <= '0;
      txd_q    <= 1'b1;
      remove_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      txd_q    <= txd_d;
      remove_q <= remove_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: enable and fifo_empty only matter in IDLE; later changes cannot disturb a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && !fifo_empty) state_d = S_POP;
      S_POP:   state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (tick_last) state_d = S_DATA;
      S_DATA:  if (tick_last && bit_last) state_d = S_STOP;
      S_STOP:  if (tick_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, shifter and frame counter; the word is captured in LOAD, one cycle after the pop.
  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    frame_d = frame_q;
    case (state_q)
      S_LOAD: begin
        shift_d = fifo_do;
        tick_d  = '0;
        bit_d   = '0;
      end
      S_START: begin
        tick_d = tick_last ? '0 : tick_q + TW'(1);
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_last ? '0 : bit_q + BW'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_STOP: begin
        if (tick_last) begin
          tick_d  = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        tick_d = '0;
        bit_d  = '0;
      end
    endcase
  end

  // Moore outputs decoded from the upcoming state so they appear registered alongside it.
  always_comb begin
    txd_d    = 1'b1;
    remove_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_POP:   remove_d = 1'b1;
      S_START: txd_d    = 1'b0;
      S_DATA:  txd_d    = shift_d[0];
      default: txd_d    = 1'b1;
    endcase
  end

  assign txd         = txd_q;
  assign fifo_remove = remove_q;
  assign busy        = busy_q;
  assign frame_count = frame_q;

endmodule
